// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg
// Shared definitions for the MAC control receive path: byte offsets of the
// control-frame fields (big-endian, counted from the first destination
// address byte), default field values and the frame classification type.
package mac_ctrl_pkg;

    localparam int DST_OFFSET      = 0;
    localparam int TYPE_OFFSET     = 12;
    localparam int OPCODE_OFFSET   = 14;
    localparam int PFC_VEC_OFFSET  = 16;
    localparam int PFC_QUANTA_BASE = 18;

    // Largest header the parser ever looks at (PFC with 8 classes).
    localparam int HDR_MAX_BYTES   = 34;

    localparam logic [15:0] ETH_TYPE_MCF   = 16'h8808;
    localparam logic [15:0] OPCODE_LFC     = 16'h0001;
    localparam logic [15:0] OPCODE_PFC     = 16'h0101;
    localparam logic [47:0] MCAST_PAUSE_DA = 48'h0180_C200_0001;

    typedef enum logic [1:0] {
        FRAME_NONE = 2'd0,
        FRAME_LFC  = 2'd1,
        FRAME_PFC  = 2'd2
    } pause_kind_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/mac_pause_timer.sv
// mac_pause_timer
// One priority-class pause timer counting down in pause quanta.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_clear       synchronous clear, wins over everything
//   i_load        load i_load_val (wins over a tick)
//   i_load_val    quanta to load; 0 ends the pause at once
//   i_tick        one-cycle quantum tick; nonzero count decrements
//   o_active      registered (count != 0)
module mac_pause_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_tick,
    output logic        o_active
);

    logic [15:0] r_count;
    logic [15:0] w_count_next;
    logic        r_active;

    always_comb begin
        w_count_next = r_count;
        if (i_clear) begin
            w_count_next = 16'd0;
        end else if (i_load) begin
            w_count_next = i_load_val;
        end else if (i_tick && (r_count != 16'd0)) begin
            w_count_next = r_count - 16'd1;
        end
    end

    // The active flag is registered from the next count so that it tracks
    // the counter on the same edge instead of trailing it by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= 16'd0;
            r_active <= 1'b0;
        end else begin
            r_count  <= w_count_next;
            r_active <= (w_count_next != 16'd0);
        end
    end

    assign o_active = r_active;

endmodule

// File: rtl/mac_pause_rx.sv
// mac_pause_rx
// Receive-side MAC control block: parses 802.3x LFC and 802.1Qbb PFC frames
// on the RX AXI-stream path, runs per-class pause timers and drives
// pause_req toward the TX scheduler. Matched frames may be marked errored
// (tuser[0]) so downstream logic drops them.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axis_*              input stream (tuser[0] = frame errored)
//   m_axis_*              output stream, one register slice behind input
//   cfg_*                 match values, enables, forward-vs-drop select
//   pause_clear           synchronous clear of all timers
//   pause_req             per-class pause active
//   stat_rx_lfc/pfc       one-cycle pulse per executed frame
//   stat_lfc/pfc_count    executed frame counters
// Optional feature macro: MAC_PAUSE_RX_STATS_EN enables the 32-bit
// saturating counters; otherwise the count ports are tied to 0.
module mac_pause_rx
    import mac_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int USER_WIDTH    = 1,
    parameter int NUM_CLASSES   = 8,
    parameter int QUANTA_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [USER_WIDTH-1:0]  s_axis_tuser,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [USER_WIDTH-1:0]  m_axis_tuser,
    input  logic [47:0]            cfg_eth_dst_mcast,
    input  logic [15:0]            cfg_eth_type,
    input  logic [15:0]            cfg_opcode_lfc,
    input  logic [15:0]            cfg_opcode_pfc,
    input  logic                   cfg_lfc_en,
    input  logic                   cfg_pfc_en,
    input  logic                   cfg_forward,
    input  logic                   pause_clear,
    output logic [NUM_CLASSES-1:0] pause_req,
    output logic                   stat_rx_lfc,
    output logic                   stat_rx_pfc,
    output logic [31:0]            stat_lfc_count,
    output logic [31:0]            stat_pfc_count
);

    localparam int BYTE_LANES = DATA_WIDTH / 8;
    localparam int HDR_BYTES  = PFC_QUANTA_BASE + 2 * NUM_CLASSES;
    localparam int MAX_BEAT   = ceil_div(HDR_MAX_BYTES, BYTE_LANES);
    localparam int BEAT_W     = $clog2(MAX_BEAT + 1);
    localparam int PRESC_W    = (QUANTA_CYCLES > 1) ? $clog2(QUANTA_CYCLES) : 1;
    // Byte 15 (last opcode byte) must be present for a frame to match.
    localparam int LEN_BEAT   = (OPCODE_OFFSET + 1) / BYTE_LANES;
    localparam int LEN_LANE   = (OPCODE_OFFSET + 1) % BYTE_LANES;

    logic [BEAT_W-1:0]                 r_beat;
    logic [HDR_BYTES-1:0][7:0]         r_hdr;
    logic [HDR_BYTES-1:0][7:0]         w_hdr;
    logic                              r_seen15;
    logic                              w_seen15;
    logic                              w_accept;
    logic [47:0]                       w_dst;
    logic [15:0]                       w_type;
    logic [15:0]                       w_opcode;
    logic [15:0]                       w_vec;
    logic [NUM_CLASSES-1:0][15:0]      w_quanta;
    pause_kind_t                       w_kind;
    logic                              w_exec;
    logic                              w_exec_lfc;
    logic                              w_exec_pfc;
    logic [USER_WIDTH-1:0]             w_user_out;
    logic [PRESC_W-1:0]                r_presc;
    logic                              w_tick;
    logic [NUM_CLASSES-1:0]            w_pause;
    logic                              r_stat_lfc;
    logic                              r_stat_pfc;
    logic                              r_m_tvalid;
    logic [DATA_WIDTH-1:0]             r_m_tdata;
    logic [KEEP_WIDTH-1:0]             r_m_tkeep;
    logic                              r_m_tlast;
    logic [USER_WIDTH-1:0]             r_m_tuser;

    assign s_axis_tready = !r_m_tvalid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;

    // Header view including the current beat. On beat 0 everything not in
    // this beat reads as zero, which clears the previous frame's fields.
    always_comb begin
        w_hdr = '0;
        for (int k = 0; k < HDR_BYTES; k++) begin
            if ((r_beat == BEAT_W'(k / BYTE_LANES)) && s_axis_tkeep[k % BYTE_LANES]) begin
                w_hdr[k] = s_axis_tdata[(k % BYTE_LANES) * 8 +: 8];
            end else if (r_beat == '0) begin
                w_hdr[k] = 8'h00;
            end else begin
                w_hdr[k] = r_hdr[k];
            end
        end
    end

    assign w_seen15 = ((r_beat == BEAT_W'(LEN_BEAT)) && s_axis_tkeep[LEN_LANE]) ||
                      ((r_beat != '0) && r_seen15);

    always_comb begin
        w_dst = '0;
        for (int i = 0; i < 6; i++) begin
            w_dst = {w_dst[39:0], w_hdr[DST_OFFSET + i]};
        end
        w_type   = {w_hdr[TYPE_OFFSET],    w_hdr[TYPE_OFFSET + 1]};
        w_opcode = {w_hdr[OPCODE_OFFSET],  w_hdr[OPCODE_OFFSET + 1]};
        w_vec    = {w_hdr[PFC_VEC_OFFSET], w_hdr[PFC_VEC_OFFSET + 1]};
        w_quanta = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            w_quanta[c] = {w_hdr[PFC_QUANTA_BASE + 2 * c], w_hdr[PFC_QUANTA_BASE + 2 * c + 1]};
        end
    end

    // LFC is tested first so a configuration with identical opcodes
    // behaves deterministically.
    always_comb begin
        w_kind = FRAME_NONE;
        if (w_seen15 && (w_dst == cfg_eth_dst_mcast) && (w_type == cfg_eth_type)) begin
            if (cfg_lfc_en && (w_opcode == cfg_opcode_lfc)) begin
                w_kind = FRAME_LFC;
            end else if (cfg_pfc_en && (w_opcode == cfg_opcode_pfc)) begin
                w_kind = FRAME_PFC;
            end
        end
    end

    assign w_exec     = w_accept && s_axis_tlast && !s_axis_tuser[0];
    assign w_exec_lfc = w_exec && (w_kind == FRAME_LFC);
    assign w_exec_pfc = w_exec && (w_kind == FRAME_PFC);

    always_comb begin
        w_user_out = s_axis_tuser;
        if ((w_exec_lfc || w_exec_pfc) && !cfg_forward) begin
            w_user_out[0] = 1'b1;
        end
    end

    // Beat counter saturates once past the header; the held fields then
    // stay stable until tlast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat   <= '0;
            r_hdr    <= '0;
            r_seen15 <= 1'b0;
        end else if (w_accept) begin
            r_hdr    <= w_hdr;
            r_seen15 <= w_seen15;
            if (s_axis_tlast) begin
                r_beat <= '0;
            end else if (r_beat != BEAT_W'(MAX_BEAT)) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= '0;
        end else if (s_axis_tready) begin
            r_m_tvalid <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                r_m_tdata <= s_axis_tdata;
                r_m_tkeep <= s_axis_tkeep;
                r_m_tlast <= s_axis_tlast;
                r_m_tuser <= w_user_out;
            end
        end
    end

    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tuser  = r_m_tuser;

    // Free-running quantum prescaler; loads never realign it, which is why
    // a pause can end up to one quantum early.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (r_presc == PRESC_W'(QUANTA_CYCLES - 1)) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick = (r_presc == PRESC_W'(QUANTA_CYCLES - 1));

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_timer
        mac_pause_timer u_timer (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_clear    (pause_clear),
            .i_load     (w_exec_lfc || (w_exec_pfc && w_vec[c])),
            .i_load_val (w_exec_lfc ? w_vec : w_quanta[c]),
            .i_tick     (w_tick),
            .o_active   (w_pause[c])
        );
    end

    assign pause_req = w_pause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_lfc <= 1'b0;
            r_stat_pfc <= 1'b0;
        end else begin
            r_stat_lfc <= w_exec_lfc;
            r_stat_pfc <= w_exec_pfc;
        end
    end

    assign stat_rx_lfc = r_stat_lfc;
    assign stat_rx_pfc = r_stat_pfc;

`ifdef MAC_PAUSE_RX_STATS_EN
    logic [31:0] r_lfc_count;
    logic [31:0] r_pfc_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfc_count <= 32'd0;
            r_pfc_count <= 32'd0;
        end else begin
            if (r_stat_lfc && (r_lfc_count != 32'hFFFF_FFFF)) begin
                r_lfc_count <= r_lfc_count + 32'd1;
            end
            if (r_stat_pfc && (r_pfc_count != 32'hFFFF_FFFF)) begin
                r_pfc_count <= r_pfc_count + 32'd1;
            end
        end
    end

    assign stat_lfc_count = r_lfc_count;
    assign stat_pfc_count = r_pfc_count;
`else
    assign stat_lfc_count = 32'd0;
    assign stat_pfc_count = 32'd0;
`endif

endmodule

// File: tb/tb_mac_pause_rx.sv
// tb_mac_pause_rx
// Self-checking bench for mac_pause_rx at DATA_WIDTH=64, QUANTA_CYCLES=64.
// Output beats are predicted when driven and compared in order when they
// leave the DUT; pause_req and stat pulses are checked against timing
// windows derived from the quantum length.
module tb_mac_pause_rx;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int NC = 8;
    localparam int QC = 64;

    localparam logic [47:0] DA_PAUSE = 48'h0180_C200_0001;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [0:0]    s_axis_tuser = '0;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [0:0]    m_axis_tuser;
    logic          cfg_forward = 1'b1;
    logic          pause_clear = 1'b0;
    logic [NC-1:0] pause_req;
    logic          stat_rx_lfc;
    logic          stat_rx_pfc;
    logic [31:0]   stat_lfc_count;
    logic [31:0]   stat_pfc_count;

    mac_pause_rx #(
        .DATA_WIDTH    (DW),
        .KEEP_WIDTH    (KW),
        .USER_WIDTH    (1),
        .NUM_CLASSES   (NC),
        .QUANTA_CYCLES (QC)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tuser      (s_axis_tuser),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tkeep      (m_axis_tkeep),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tuser      (m_axis_tuser),
        .cfg_eth_dst_mcast (DA_PAUSE),
        .cfg_eth_type      (16'h8808),
        .cfg_opcode_lfc    (16'h0001),
        .cfg_opcode_pfc    (16'h0101),
        .cfg_lfc_en        (1'b1),
        .cfg_pfc_en        (1'b1),
        .cfg_forward       (cfg_forward),
        .pause_clear       (pause_clear),
        .pause_req         (pause_req),
        .stat_rx_lfc       (stat_rx_lfc),
        .stat_rx_pfc       (stat_rx_pfc),
        .stat_lfc_count    (stat_lfc_count),
        .stat_pfc_count    (stat_pfc_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    beat_t       expQ[$];
    beat_t       obsBeat;
    beat_t       expBeat;
    int          compared = 0;
    int          mismatched = 0;
    int          lfcPulses = 0;
    int          pfcPulses = 0;
    logic        randReady = 1'b0;
    logic        class1Seen = 1'b0;
    logic [7:0]  frameBytes [0:127];
    int          frameLen = 0;
    logic [15:0] quantaTab [0:7];

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Output monitor: a beat seen valid&ready at negedge transfers on the
    // following posedge, so it is compared against the scoreboard head here.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stat_rx_lfc) lfcPulses++;
            if (stat_rx_pfc) pfcPulses++;
            if (m_axis_tvalid && m_axis_tready) begin
                obsBeat.data = m_axis_tdata;
                obsBeat.keep = m_axis_tkeep;
                obsBeat.last = m_axis_tlast;
                obsBeat.user = m_axis_tuser[0];
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedBeat", 128'(obsBeat), 128'd0);
                end else begin
                    expBeat = expQ.pop_front();
                    checkOutput("outBeat", 128'(obsBeat), 128'(expBeat));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic buildFrame(input logic [47:0] dst, input logic [15:0] opcode,
                              input logic [15:0] field16, input int len);
        for (int i = 0; i < 128; i++) frameBytes[i] = 8'(i);
        for (int i = 0; i < 6; i++) frameBytes[i] = dst[47 - 8 * i -: 8];
        for (int i = 6; i < 12; i++) frameBytes[i] = 8'hA0 + 8'(i);
        frameBytes[12] = 8'h88;
        frameBytes[13] = 8'h08;
        frameBytes[14] = opcode[15:8];
        frameBytes[15] = opcode[7:0];
        frameBytes[16] = field16[15:8];
        frameBytes[17] = field16[7:0];
        for (int c = 0; c < 8; c++) begin
            frameBytes[18 + 2 * c] = quantaTab[c][15:8];
            frameBytes[19 + 2 * c] = quantaTab[c][7:0];
        end
        frameLen = len;
    endtask

    // Caller is at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                 input logic l, input logic u, input logic drop);
        beat_t e;
        int    waitCnt;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        e.data = d;
        e.keep = k;
        e.last = l;
        e.user = u | (drop & l);
        expQ.push_back(e);
        waitCnt = 0;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            waitCnt++;
            if (waitCnt > 1000) begin
                checkOutput("acceptTimeout", 128'd0, 128'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
    endtask

    task automatic sendFrame(input logic err, input logic drop);
        int            nBeats;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        nBeats = (frameLen + 7) / 8;
        for (int b = 0; b < nBeats; b++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 8; j++) begin
                if (b * 8 + j < frameLen) begin
                    d[j * 8 +: 8] = frameBytes[b * 8 + j];
                    k[j] = 1'b1;
                end
            end
            applyStimulus(d, k, (b == nBeats - 1), (b == nBeats - 1) ? err : 1'b0, drop);
        end
    endtask

    int dur;
    int t0;
    int t2;
    int cyc;
    int drain;
    int expLfc;
    int expPfc;

    initial begin
        for (int c = 0; c < 8; c++) quantaTab[c] = 16'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        waitCycles(2);

        checkOutput("resetPause", 128'(pause_req), 128'd0);
        checkOutput("resetMValid", 128'(m_axis_tvalid), 128'd0);
        checkOutput("resetSReady", 128'(s_axis_tready), 128'd1);
        checkOutput("resetStatLfc", 128'(stat_lfc_count), 128'd0);
        checkOutput("resetStatPfc", 128'(stat_pfc_count), 128'd0);

        // LFC quanta 3: 129..192 cycles of pause on all classes.
        buildFrame(DA_PAUSE, 16'h0001, 16'd3, 60);
        sendFrame(1'b0, 1'b0);
        checkOutput("lfcPauseOn", 128'(pause_req), 128'hFF);
        dur = 0;
        while (pause_req != '0 && dur < 300) begin
            @(posedge clk);
            #1;
            dur++;
        end
        checkOutput("lfcDurationOk", 128'(dur >= 129 && dur <= 192), 128'd1);
        checkOutput("lfcPulseCount", 128'(lfcPulses), 128'd1);

        // PFC vector 0x0005, c0=10 c1=7 c2=20.
        quantaTab[0] = 16'd10;
        quantaTab[1] = 16'd7;
        quantaTab[2] = 16'd20;
        buildFrame(DA_PAUSE, 16'h0101, 16'h0005, 60);
        sendFrame(1'b0, 1'b0);
        checkOutput("pfcPauseOn", 128'(pause_req), 128'h05);
        t0 = -1;
        t2 = -1;
        cyc = 0;
        while ((t0 < 0 || t2 < 0) && cyc < 1500) begin
            @(posedge clk);
            #1;
            cyc++;
            if (pause_req[1]) class1Seen = 1'b1;
            if (t0 < 0 && !pause_req[0]) t0 = cyc;
            if (t2 < 0 && !pause_req[2]) t2 = cyc;
        end
        checkOutput("pfcClass0Fall", 128'(t0 >= 577 && t0 <= 640), 128'd1);
        checkOutput("pfcFallGap", 128'(t2 - t0), 128'd640);
        checkOutput("pfcClass1Idle", 128'(class1Seen), 128'd0);
        checkOutput("pfcPulseCount", 128'(pfcPulses), 128'd1);

        // Active pause cancelled by LFC quanta 0.
        buildFrame(DA_PAUSE, 16'h0001, 16'd100, 60);
        sendFrame(1'b0, 1'b0);
        checkOutput("lfc100On", 128'(pause_req), 128'hFF);
        waitCycles(20);
        buildFrame(DA_PAUSE, 16'h0001, 16'd0, 60);
        sendFrame(1'b0, 1'b0);
        checkOutput("lfcZeroClears", 128'(pause_req), 128'h00);

        // Errored PFC frame must not touch class 0.
        buildFrame(DA_PAUSE, 16'h0001, 16'd50, 60);
        sendFrame(1'b0, 1'b0);
        quantaTab[0] = 16'd0;
        buildFrame(DA_PAUSE, 16'h0101, 16'h0001, 60);
        sendFrame(1'b1, 1'b0);
        checkOutput("errPfcIgnored", 128'(pause_req), 128'hFF);
        waitCycles(3);
        checkOutput("errPfcNoPulse", 128'(pfcPulses), 128'd1);
        pause_clear = 1'b1;
        waitCycles(1);
        pause_clear = 1'b0;
        checkOutput("clearPulse", 128'(pause_req), 128'h00);

        // Drop mode with a 50% ready pattern; boundary frame lengths.
        cfg_forward = 1'b0;
        randReady = 1'b1;
        buildFrame(DA_PAUSE, 16'h0001, 16'd5, 60);
        sendFrame(1'b0, 1'b1);
        checkOutput("dropLfcOn", 128'(pause_req), 128'hFF);
        buildFrame(48'h0180_C200_0002, 16'h0001, 16'd0, 60);
        sendFrame(1'b0, 1'b0);
        buildFrame(DA_PAUSE, 16'h0001, 16'd0, 15);
        sendFrame(1'b0, 1'b0);
        checkOutput("shortFrameNoMatch", 128'(pause_req), 128'hFF);
        buildFrame(DA_PAUSE, 16'h0001, 16'd0, 16);
        sendFrame(1'b0, 1'b1);
        checkOutput("len16Matches", 128'(pause_req), 128'h00);
        drain = 0;
        while (expQ.size() != 0 && drain < 200) begin
            waitCycles(1);
            drain++;
        end
        randReady = 1'b0;
        cfg_forward = 1'b1;
        waitCycles(3);
        expLfc = 6;
        expPfc = 1;
        checkOutput("lfcPulseTotal", 128'(lfcPulses), 128'(expLfc));
        checkOutput("pfcPulseTotal", 128'(pfcPulses), 128'(expPfc));
`ifdef MAC_PAUSE_RX_STATS_EN
        checkOutput("statLfcCount", 128'(stat_lfc_count), 128'(expLfc));
        checkOutput("statPfcCount", 128'(stat_pfc_count), 128'(expPfc));
`else
        checkOutput("statLfcCount", 128'(stat_lfc_count), 128'd0);
        checkOutput("statPfcCount", 128'(stat_pfc_count), 128'd0);
`endif

        // Quanta 0xFFFF must hold, then clear coinciding with a load wins.
        buildFrame(DA_PAUSE, 16'h0001, 16'hFFFF, 60);
        sendFrame(1'b0, 1'b0);
        waitCycles(200);
        checkOutput("maxQuantaHeld", 128'(pause_req), 128'hFF);
        pause_clear = 1'b1;
        buildFrame(DA_PAUSE, 16'h0001, 16'd9, 60);
        sendFrame(1'b0, 1'b0);
        checkOutput("clearBeatsLoad", 128'(pause_req), 128'h00);
        pause_clear = 1'b0;
        waitCycles(2);
        checkOutput("clearStays", 128'(pause_req), 128'h00);

        drain = 0;
        while (expQ.size() != 0 && drain < 200) begin
            waitCycles(1);
            drain++;
        end
        checkOutput("scoreboardDrain", 128'(expQ.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mac_pause_rx.md
Name: mac_pause_rx

Overview:
Receive-side MAC control block with pause execution. It sits on the MAC RX AXI-stream path and parses MAC control frames at any byte-granular width. It decodes both 802.3x link flow control (LFC) and 802.1Qbb priority flow control (PFC), and runs per-class pause-quanta timers that drive a pause request vector to the TX scheduler. Matching frames can optionally be dropped from the data stream by marking them errored.

Parameters:
DATA_WIDTH, 8, stream data width; must be a multiple of 8.
KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
USER_WIDTH, 1, tuser width; bit 0 is the frame-error flag.
NUM_CLASSES, 8, number of priority classes (1..8).
QUANTA_CYCLES, 64, clk cycles per pause quantum (512 bit times); must be ≥1.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axis_tdata  in  DATA_WIDTH  input stream data
s_axis_tkeep  in  KEEP_WIDTH  input byte enables
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input end of frame
s_axis_tuser  in  USER_WIDTH  input user; bit 0 = frame errored
m_axis_tdata  out  DATA_WIDTH  output stream data
m_axis_tkeep  out  KEEP_WIDTH  output byte enables
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output end of frame
m_axis_tuser  out  USER_WIDTH  output user
cfg_eth_dst_mcast  in  48  expected destination address, e.g. 01:80:C2:00:00:01
cfg_eth_type  in  16  expected ethertype, e.g. 0x8808
cfg_opcode_lfc  in  16  LFC opcode, e.g. 0x0001
cfg_opcode_pfc  in  16  PFC opcode, e.g. 0x0101
cfg_lfc_en  in  1  enable LFC execution
cfg_pfc_en  in  1  enable PFC execution
cfg_forward  in  1  1 = forward matched frames unmodified
pause_clear  in  1  synchronous clear of all timers
pause_req  out  NUM_CLASSES  per-class pause active
stat_rx_lfc  out  1  one-cycle pulse per executed LFC frame
stat_rx_pfc  out  1  one-cycle pulse per executed PFC frame
stat_lfc_count  out  32  executed LFC frame count (optional feature)
stat_pfc_count  out  32  executed PFC frame count (optional feature)

Behaviour:
- Reset:
  - All outputs are 0; timers are 0; the parser is at beat 0.
  - Reset is asynchronous assert, synchronous deassert externally.
  - Reset mid-frame: the remainder of that frame is parsed as if from beat 0 on the next tvalid. Bench tolerance only; no recovery is required.
- Datapath:
  - Single register slice; latency is 1 cycle.
  - s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - tdata, tkeep and tlast pass through unchanged.
- Parser:
  - A beat counter (clog2 of ceil(34/BYTE_LANES)+1 bits) advances on each accepted beat, saturates, and clears after tlast.
  - Byte offsets, big-endian: 0-5 dst, 12-13 type, 14-15 opcode, 16-17 class-enable vector, 18+2i..19+2i quanta for class i.
  - Bytes beyond offset 17+2*NUM_CLASSES are ignored.
  - Captured fields are cleared at the start of each frame.
- Match: dst == cfg_eth_dst_mcast, type == cfg_eth_type, opcode equals LFC or PFC, and that type is enabled.
  - For LFC, the quanta field is bytes 16-17.
  - Frames with tkeep ending before byte 15 never match.
- Execute on the accepted tlast beat, only if s_axis_tuser[0]==0 and the frame matched:
  - LFC loads all timers with the quanta value.
  - PFC loads timer i with its quanta for every enabled bit i < NUM_CLASSES; other timers are untouched.
  - A loaded value of 0 clears pause immediately.
  - If cfg_forward==0, output tuser[0] is set on that tlast beat.
  - The matching stat pulse fires one cycle after the tlast beat.
- Timers:
  - A shared free-running prescaler counts 0..QUANTA_CYCLES-1 and emits a tick on wrap.
  - On each tick, every nonzero 16-bit timer decrements by 1.
  - pause_req[i] = (timer[i] != 0), registered.
  - Pause duration accuracy is −1 quantum / +0.
- Priority on a same-cycle conflict: pause_clear > frame load > tick decrement.
- Quanta 0xFFFF are honoured, not wrapped.
- The prescaler is never reset by a load.

Optional Feature:
MAC_PAUSE_RX_STATS_EN:
- Defined: stat_lfc_count and stat_pfc_count are 32-bit saturating counters incremented with their stat pulses. They are cleared by reset only.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Package mac_ctrl_pkg holds:
  - field byte-offset localparams (DST, TYPE, OPCODE, PFC_VEC, PFC_QUANTA_BASE);
  - default constants ETH_TYPE_MCF=0x8808, OPCODE_LFC=0x0001, OPCODE_PFC=0x0101, MCAST_PAUSE_DA.
- Sub-module mac_pause_timer: one class timer with load, clear and tick inputs and an active output. It is instantiated NUM_CLASSES times.

Test Plan:
- DATA_WIDTH=8, QUANTA_CYCLES=64, LFC with quanta 3 -> pause_req=0xFF starting 1 cycle after the execute edge, dropping after 129..192 cycles; stat_rx_lfc pulses once.
- DATA_WIDTH=64, PFC with vector 0x0005 and quanta c0=10, c1=7, c2=20 -> pause_req[0] and [2] set, [1] stays 0; c0 falls about 640 cycles before c2.
- Active LFC pause followed by an LFC frame with quanta 0 -> pause_req=0 the cycle after tlast.
- Matching PFC frame with tuser[0]=1 on tlast -> no timer change, no stat pulse, frame forwarded unchanged.
- cfg_forward=0 with m_axis_tready toggling 50% -> all beats are delivered in order, tlast beat has tuser[0]=1, and no beat is lost or duplicated.
- pause_clear asserted on the same cycle as a load tick -> all timers 0, pause_req=0 next cycle.
